free_list: RTL and testbench

//  Physical-register free list for the rename stage. Tracks which physical registers are free
//  in a one-bit-per-register mask and grants the lowest-numbered free register on request.

---
 rtl/core_pkg.sv | 9 +
 rtl/free_list_pick_lowest.sv | 23 ++
 rtl/free_list.sv | 85 ++++++++
 tb/tb_free_list.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Core-wide rename parameters: physical register count and index type.
package core_pkg;

    localparam int PREGS  = 64;
    localparam int PREG_W = 6;

    typedef logic [PREG_W-1:0] preg_idx_t;

endpackage

// File: rtl/free_list_pick_lowest.sv
// Lowest-set-bit priority encoder: reports whether any bit is set and the index of the lowest one.
module free_list_pick_lowest #(
    parameter int W     = 64,
    parameter int IDX_W = 6
) (
    input  logic [W-1:0]     mask,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        found = |mask;
        idx   = '0;
        // Scan from the top down so the last hit, the lowest index, wins.
        for (int i = W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/free_list.sv
// Physical-register free list: one-bit-per-register mask, grants the lowest free register,
// accepts one returned register per cycle which is eligible for the same-cycle grant.
module free_list
    import core_pkg::*;
#(
    parameter int PHYS_REGS = PREGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_en,
    output logic [PREG_W-1:0] alloc_phys,
    output logic              alloc_valid,
    input  logic              free_en,
    input  logic [PREG_W-1:0] free_phys
);

    localparam logic [PREG_W:0] REG_LIMIT = (PREG_W + 1)'(PHYS_REGS);

    logic [PHYS_REGS-1:0] free_mask;
    logic [PHYS_REGS-1:0] free_mask_d;
    logic [PHYS_REGS-1:0] free_onehot;
    logic [PHYS_REGS-1:0] grant_onehot;
    logic [PHYS_REGS-1:0] avail;
    logic                 any_avail;
    preg_idx_t            grant_idx;
    logic                 alloc_valid_d;
    logic                 alloc_valid_q;
    preg_idx_t            alloc_phys_d;
    preg_idx_t            alloc_phys_q;

    // Out-of-range indices never match a mask position, so they fall out of the decode.
    always_comb begin
        free_onehot = '0;
        for (int i = 0; i < PHYS_REGS; i++) begin
            free_onehot[i] = free_en && (free_phys == PREG_W'(i));
        end
    end

    assign avail = free_mask | free_onehot;

    free_list_pick_lowest #(
        .W     (PHYS_REGS),
        .IDX_W (PREG_W)
    ) u_pick (
        .mask  (avail),
        .found (any_avail),
        .idx   (grant_idx)
    );

    always_comb begin
        alloc_valid_d = alloc_en && any_avail;
        alloc_phys_d  = alloc_valid_d ? grant_idx : '0;
        grant_onehot  = '0;
        for (int i = 0; i < PHYS_REGS; i++) begin
            grant_onehot[i] = alloc_valid_d && (grant_idx == PREG_W'(i));
        end
        free_mask_d = avail & ~grant_onehot;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            free_mask     <= '1;
            alloc_valid_q <= 1'b0;
            alloc_phys_q  <= '0;
        end else begin
            free_mask     <= free_mask_d;
            alloc_valid_q <= alloc_valid_d;
            alloc_phys_q  <= alloc_phys_d;
        end
    end

    assign alloc_valid = alloc_valid_q;
    assign alloc_phys  = alloc_phys_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && free_en) begin
            assert ({1'b0, free_phys} < REG_LIMIT)
            else $error("free_list: free of out-of-range register %0d", free_phys);
        end
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a set-based model of the free list.
module tb_free_list;

    localparam int N = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       alloc_en = 1'b0;
    logic [5:0] alloc_phys;
    logic       alloc_valid;
    logic       free_en = 1'b0;
    logic [5:0] free_phys = '0;

    int vectors = 0;
    int miscompares = 0;

    // Model: which registers are free, what was granted last edge, how many are out.
    bit [N-1:0] m_free;
    bit         m_valid;
    bit [5:0]   m_phys;
    int         m_alloc_cnt;

    free_list #(.PHYS_REGS(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .alloc_en    (alloc_en),
        .alloc_phys  (alloc_phys),
        .alloc_valid (alloc_valid),
        .free_en     (free_en),
        .free_phys   (free_phys)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: return first, then hand out the lowest-numbered free register.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_free      = '1;
            m_valid     = 1'b0;
            m_phys      = '0;
            m_alloc_cnt = 0;
        end else begin
            if (free_en && int'(free_phys) < N && !m_free[free_phys]) begin
                m_free[free_phys] = 1'b1;
                m_alloc_cnt--;
            end
            m_valid = 1'b0;
            m_phys  = '0;
            if (alloc_en) begin
                for (int i = 0; i < N; i++) begin
                    if (m_free[i]) begin
                        m_valid   = 1'b1;
                        m_phys    = 6'(i);
                        m_free[i] = 1'b0;
                        m_alloc_cnt++;
                        break;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            check("cyc_valid", 64'(alloc_valid), 64'(m_valid));
            check("cyc_phys",  64'(alloc_phys),  64'(m_phys));
            check("cyc_mask",  dut.free_mask,    m_free);
        end
    end

    task automatic do_cycle(input logic ae, input logic fe, input logic [5:0] fp);
        alloc_en  = ae;
        free_en   = fe;
        free_phys = fp;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        alloc_en = 1'b0;
        free_en  = 1'b0;
        reset    = 1'b1;
        #1;
        check("rst_valid", 64'(alloc_valid), 64'd0);
        check("rst_phys",  64'(alloc_phys),  64'd0);
        check("rst_mask",  dut.free_mask,    {64{1'b1}});
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #2;
        do_reset();

        // Isolated alloc pulses: 0..9 in order, idle cycles show no grant.
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b1, 1'b0, '0);
            check("pulse_valid", 64'(alloc_valid), 64'd1);
            check("pulse_phys",  64'(alloc_phys),  64'(i));
            do_cycle(1'b0, 1'b0, '0);
            check("idle_valid", 64'(alloc_valid), 64'd0);
            check("idle_phys",  64'(alloc_phys),  64'd0);
        end
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, 1'b1, 6'(i));
            check("freeonly_valid", 64'(alloc_valid), 64'd0);
        end
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1, 1'b0, '0);
            check("realloc_phys", 64'(alloc_phys), 64'(i));
        end
        // Double free of a free register is a no-op.
        do_cycle(1'b0, 1'b1, 6'd40);
        check("idem_mask", dut.free_mask, {{54{1'b1}}, 10'd0});

        // Exhaustion.
        do_reset();
        for (int i = 0; i < N; i++) begin
            do_cycle(1'b1, 1'b0, '0);
            check("exh_phys", 64'(alloc_phys), 64'(i));
        end
        do_cycle(1'b1, 1'b0, '0);
        check("empty_valid", 64'(alloc_valid), 64'd0);
        check("empty_phys",  64'(alloc_phys),  64'd0);
        check("empty_mask",  dut.free_mask,    64'd0);

        // Strict lowest-index priority.
        do_reset();
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, '0);
        do_cycle(1'b0, 1'b1, 6'd2);
        do_cycle(1'b0, 1'b1, 6'd4);
        do_cycle(1'b1, 1'b0, '0);
        check("prio_phys", 64'(alloc_phys), 64'd2);

        // Concurrent free+alloc: freed 5 is lower than the free 62, so it wins at once.
        do_reset();
        for (int i = 0; i < N - 2; i++) do_cycle(1'b1, 1'b0, '0);
        do_cycle(1'b1, 1'b1, 6'd5);
        check("conc_phys", 64'(alloc_phys), 64'd5);
        check("conc_mask", dut.free_mask, 64'hC000_0000_0000_0000);
        do_cycle(1'b1, 1'b0, '0);
        check("conc_next1", 64'(alloc_phys), 64'(N - 2));
        do_cycle(1'b1, 1'b0, '0);
        check("conc_next2", 64'(alloc_phys), 64'(N - 1));

        // Random stress with an asynchronous reset in the middle.
        do_reset();
        for (int c = 0; c < 200; c++) begin
            if (c == 100) begin
                alloc_en = 1'b1;
                #1;
                do_reset();
            end
            do_cycle(($urandom % 100) < 40, ($urandom % 100) < 30, 6'($urandom % N));
        end
        do_cycle(1'b0, 1'b0, '0);
        check("popcount", 64'(N - $countones(dut.free_mask)), 64'(m_alloc_cnt));

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
